// File: rtl/dot_matrix_scan_ctrl.sv
// dot_matrix_scan_ctrl: double-buffered 8x8 LED matrix scanner with anti-ghost blanking and frame-boundary swap; DOT_BRIGHTNESS_EN adds PWM brightness
module dot_matrix_scan_ctrl #(
    parameter int DRIVE_CYCLES = 25000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
`ifdef DOT_BRIGHTNESS_EN
    input  logic [2:0] brightness,
`endif
    output logic       swap_ack,
    output logic       frame_start,
    output logic [7:0] dot_row,
    output logic [7:0] dot_col
);
    typedef enum logic [1:0] {OFF, BLANK, DRIVE} state_t;
    state_t           state, state_n;
    logic [2:0]       row, row_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       mem [2][8];
    logic             sel, wrap, frame_edge, do_swap, lit, show, blank_end, drive_end;

    assign blank_end  = cnt == CNT_W'(BLANK_CYCLES - 1);
    assign drive_end  = cnt == CNT_W'(DRIVE_CYCLES - 1);
    assign frame_edge = enable && state == BLANK && row == 3'd0 && cnt == '0;
    assign do_swap    = swap_req && ((frame_edge && wrap) || state == OFF);
    assign show       = enable && state == DRIVE && lit;

`ifdef DOT_BRIGHTNESS_EN
    logic [2:0] bright;
    // Latch brightness at DRIVE entry so a row's duty cycle never changes mid-row
    always_ff @(posedge clk or posedge reset)
        if (reset) bright <= 3'd7;
        else if (enable && state == BLANK && blank_end) bright <= brightness;
    assign lit = 32'(cnt) < (((32'(bright) + 32'd1) * 32'(DRIVE_CYCLES)) >> 3);
`else
    assign lit = 1'b1;
`endif

    // Phase register: state, row index and per-phase counter
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= BLANK;
            row   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            row   <= row_n;
            cnt   <= cnt_n;
        end

    // Blank/drive alternation per row; disable drops to OFF and re-enable restarts at row 0
    always_comb begin
        state_n = state;
        row_n   = row;
        cnt_n   = cnt + CNT_W'(1);
        if (!enable) begin
            state_n = OFF;
            row_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                OFF: begin
                    state_n = BLANK;
                    row_n   = '0;
                    cnt_n   = '0;
                end
                BLANK: if (blank_end) begin
                    state_n = DRIVE;
                    cnt_n   = '0;
                end
                DRIVE: if (drive_end) begin
                    state_n = BLANK;
                    row_n   = row + 3'd1;
                    cnt_n   = '0;
                end
                default: state_n = BLANK;
            endcase
        end
    end

    // Buffers, swap and registered outputs; the swap is taken on the edge that shows row 0 BLANK
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mem[0][i] <= '0;
                mem[1][i] <= '0;
            end
            sel         <= 1'b0;
            wrap        <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            dot_row     <= '0;
            dot_col     <= '0;
        end else begin
            if (wr_en) mem[~sel][wr_row] <= wr_data;
            if (do_swap) sel <= ~sel;
            wrap        <= enable && state == DRIVE && row == 3'd7 && drive_end;
            swap_ack    <= do_swap;
            frame_start <= frame_edge;
            dot_row     <= show ? 8'd1 << row : '0;
            dot_col     <= show ? mem[sel][row] : '0;
        end
endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// tb_dot_matrix_scan_ctrl: table, directed and random checks of the scan controller against a frame-phase model
module tb_dot_matrix_scan_ctrl;
    localparam int D = 8;
    localparam int B = 2;
    localparam int ROWP = D + B;
    localparam int FRAMEP = 8 * ROWP;

    logic clk = 1'b0;
    logic reset, enable, wr_en, swap_req;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic swap_ack, frame_start;
    logic [7:0] dot_row, dot_col;
    logic [17:0] outs;
    int br = 7;
`ifdef DOT_BRIGHTNESS_EN
    logic [2:0] brightness = 3'd7;
`endif

    always #5 clk = ~clk;

    dot_matrix_scan_ctrl #(.DRIVE_CYCLES(D), .BLANK_CYCLES(B), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
        .wr_data(wr_data), .swap_req(swap_req),
`ifdef DOT_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .swap_ack(swap_ack), .frame_start(frame_start), .dot_row(dot_row), .dot_col(dot_col));

    assign outs = {frame_start, swap_ack, dot_row, dot_col};

    typedef struct {
        logic [2:0] row;
        logic [7:0] data;
    } vec_t;
    vec_t tbl[8];

    int checks = 0, errors = 0;
    logic [7:0] mf[8], mb[8];
    bit moff, mwrap;
    int nph, cur_ph;
    logic e_fs, e_ack;
    logic [7:0] e_row, e_col;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mf[i] = '0;
            mb[i] = '0;
        end
        moff = 0; mwrap = 0; nph = 0; cur_ph = -1;
        e_fs = 0; e_ack = 0; e_row = '0; e_col = '0;
    endtask

    task automatic model_swap();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t = mf[i]; mf[i] = mb[i]; mb[i] = t;
        end
        e_ack = 1;
    endtask

    task automatic model_edge();
        int w, r, lim;
        e_fs = 0; e_ack = 0; e_row = '0; e_col = '0; cur_ph = -1;
        lim = ((br + 1) * D) >> 3;
        if (wr_en) mb[wr_row] = wr_data;
        if (moff) begin
            if (swap_req) model_swap();
            if (enable) begin moff = 0; nph = 0; end
            mwrap = 0;
        end else if (!enable) begin
            moff = 1; mwrap = 0;
        end else begin
            cur_ph = nph;
            w = nph % ROWP;
            r = nph / ROWP;
            e_fs = (nph == 0);
            if (nph == 0 && mwrap && swap_req) model_swap();
            if (w >= B && (w - B) < lim) begin
                e_row = 8'(1 << r);
                e_col = mf[r];
            end
            mwrap = (nph == FRAMEP - 1);
            nph = (nph + 1) % FRAMEP;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("outputs", {14'd0, outs}, {14'd0, e_fs, e_ack, e_row, e_col});
    endtask

    task automatic wait_ph(input int p);
        int k = 0;
        while (cur_ph != p && k < 300) begin cyc(); k++; end
        if (cur_ph != p) begin
            checks++; errors++;
            $display("FAIL wait_ph: phase %0d not reached, at %0d", p, cur_ph);
        end
    endtask

    initial begin
        int k, lit;
        bit req;
        reset = 0; enable = 0; wr_en = 0; wr_row = '0; wr_data = '0; swap_req = 0;
        tbl[0] = '{3'd0, 8'h81}; tbl[1] = '{3'd1, 8'h42};
        tbl[2] = '{3'd2, 8'h24}; tbl[3] = '{3'd3, 8'h18};
        tbl[4] = '{3'd4, 8'h18}; tbl[5] = '{3'd5, 8'h24};
        tbl[6] = '{3'd6, 8'h42}; tbl[7] = '{3'd7, 8'h81};
        #1 reset = 1; model_reset();
        #1 check("reset_state", {14'd0, outs}, 32'd0);
        @(posedge clk); #1 reset = 0; enable = 1;
        cyc(); check("first_fs", {31'd0, frame_start}, 32'd1);
        cyc(); cyc(); check("first_row", {16'd0, dot_row, dot_col}, 32'h0100);
        wait_ph(15);
        reset = 1; model_reset();
        #1 check("reset_mid_drive", {14'd0, outs}, 32'd0);
        @(posedge clk); #1 reset = 0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_row = tbl[i].row; wr_data = tbl[i].data; cyc();
        end
        wr_en = 0;
        swap_req = 1;
        k = 0;
        do begin cyc(); k++; end while (!swap_ack && k < 200);
        check("swap_ack_seen", {31'd0, swap_ack}, 32'd1);
        check("ack_with_fs", {31'd0, frame_start}, 32'd1);
        swap_req = 0;
        for (int j = 1; j < FRAMEP; j++) begin
            if (j == 70) swap_req = 1;
            cyc();
            if (j % ROWP == B)
                check("pattern_row", {16'd0, dot_row, dot_col},
                      {16'd0, 8'(1 << tbl[j / ROWP].row), tbl[j / ROWP].data});
        end
        cyc(); check("ack_period", {30'd0, swap_ack, frame_start}, 32'd3);
        swap_req = 0;
        for (int j = 1; j < FRAMEP; j++) begin
            if (j == 30) swap_req = 1;
            if (j == 50) swap_req = 0;
            cyc();
        end
        cyc(); check("cancel_no_ack", {30'd0, swap_ack, frame_start}, 32'd1);
        for (int j = 1; j < FRAMEP; j++) begin
            if (j == 75) swap_req = 1;
            cyc();
        end
        wr_en = 1; wr_row = 3'd0; wr_data = 8'hFF;
        cyc(); check("coinc_ack", {31'd0, swap_ack}, 32'd1);
        wr_en = 0; swap_req = 0;
        cyc(); cyc(); check("coinc_write", {24'd0, dot_col}, 32'hFF);
        wait_ph(45);
        enable = 0;
        cyc(); check("off_blank", {16'd0, dot_row, dot_col}, 32'd0);
        swap_req = 1;
        cyc(); check("off_ack", {31'd0, swap_ack}, 32'd1);
        swap_req = 0;
        cyc(); check("off_ack_pulse", {31'd0, swap_ack}, 32'd0);
        enable = 1;
        cyc(); cyc(); check("restart_fs", {31'd0, frame_start}, 32'd1);
`ifdef DOT_BRIGHTNESS_EN
        brightness = 3'd1; br = 1; lit = 0;
        for (int j = 1; j < FRAMEP; j++) begin
            cyc();
            if (dot_row != 8'd0) lit++;
        end
        check("brightness_duty", lit, 32'd16);
        brightness = 3'd7; br = 7;
`endif
        req = 0;
        for (int n = 0; n < 4000; n++) begin
            if (swap_ack) req = 0;
            else if (!req && $urandom_range(99) == 0) req = 1;
            else if (req && $urandom_range(299) == 0) req = 0;
            swap_req = req;
            if ($urandom_range(199) == 0) enable = ~enable;
            wr_en = ($urandom_range(3) == 0);
            wr_row = 3'($urandom_range(7));
            wr_data = 8'($urandom_range(255));
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
